// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator: issues one aligned line request per cycle, replays after a miss,
// and applies redirects and stall. Optional perf counters are enabled by FETCH_PERF_CNT_EN.
module fetch_pc_gen #(
  parameter int                   ADR_WIDTH    = 64,
  parameter int                   RETURN_BYTES = 16,
  parameter logic [ADR_WIDTH-1:0] RESET_PC     = ADR_WIDTH'(64'h8000_0000)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 redirect_valid,
  input  logic [ADR_WIDTH-1:0] redirect_pc,
  input  logic                 stall,
  output logic [ADR_WIDTH-1:0] address,
  output logic                 req_valid,
  input  logic                 data_valid,
  input  logic                 cache_miss,
  output logic                 resp_valid,
  output logic [ADR_WIDTH-1:0] resp_pc,
  output logic [31:0]          perf_hits,
  output logic [31:0]          perf_misses,
  output logic                 dbg_state_o
);

  // Handshake: a request is issued in any cycle req_valid=1 (the cache has no ready);
  // the answer (data_valid or cache_miss) arrives exactly one cycle later.
  typedef enum logic [0:0] {
    FETCH     = 1'b0,
    MISS_WAIT = 1'b1
  } state_e;

  localparam logic [ADR_WIDTH-1:0] LINE_STEP   = ADR_WIDTH'(RETURN_BYTES);
  localparam logic [ADR_WIDTH-1:0] ALIGN_MASK  = ~(LINE_STEP - 1'b1);
  localparam logic [ADR_WIDTH-1:0] RESET_PC_AL = RESET_PC & ALIGN_MASK;

  state_e               state_q, state_d;
  logic [ADR_WIDTH-1:0] pc_q, pc_d;
  logic                 inflight_q, inflight_d;
  logic [ADR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                 miss_accept;
  logic                 can_fetch;

  assign address     = pc_q;
  assign resp_pc     = inflight_pc_q;
  assign dbg_state_o = state_q;

  // MISS_WAIT leaves on the first cycle cache_miss is low, and the replay issues that cycle.
  assign can_fetch   = (state_q == FETCH) || !cache_miss;
  assign req_valid   = can_fetch && !stall && !redirect_valid && !cache_miss && !rst;
  assign resp_valid  = data_valid && inflight_q && !redirect_valid;
  assign miss_accept = cache_miss && inflight_q && !redirect_valid;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc & ALIGN_MASK;
      state_d = FETCH;
    end else if (miss_accept) begin
      // Rewind the speculative increment so the missed line is fetched again.
      pc_d    = inflight_pc_q;
      state_d = MISS_WAIT;
    end else if (req_valid) begin
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
      pc_d          = pc_q + LINE_STEP;
      state_d       = FETCH;
    end else if (state_q == MISS_WAIT && !cache_miss) begin
      state_d = FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC_AL;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC_AL;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_hits_q, perf_hits_d;
  logic [31:0] perf_misses_q, perf_misses_d;

  always_comb begin
    perf_hits_d   = perf_hits_q;
    perf_misses_d = perf_misses_q;
    if (resp_valid && (perf_hits_q != 32'hFFFF_FFFF)) begin
      perf_hits_d = perf_hits_q + 32'd1;
    end
    if (miss_accept && (perf_misses_q != 32'hFFFF_FFFF)) begin
      perf_misses_d = perf_misses_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hits_q   <= 32'd0;
      perf_misses_q <= 32'd0;
    end else begin
      perf_hits_q   <= perf_hits_d;
      perf_misses_q <= perf_misses_d;
    end
  end

  assign perf_hits   = perf_hits_q;
  assign perf_misses = perf_misses_q;
`else
  assign perf_hits   = 32'd0;
  assign perf_misses = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: a line-level fetch model predicts every request and response;
// a negedge monitor pops the expected queues whenever the DUT raises req_valid or resp_valid.
module tb_fetch_pc_gen;
  localparam int              AW     = 64;
  localparam int              RB     = 16;
  localparam logic [AW-1:0]   RST_PC = 64'h8000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          stall;
  logic [AW-1:0] address;
  logic          req_valid;
  logic          data_valid;
  logic          cache_miss;
  logic          resp_valid;
  logic [AW-1:0] resp_pc;
  logic [31:0]   perf_hits;
  logic [31:0]   perf_misses;
  logic          dbg_state_o;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fetch_pc_gen #(.ADR_WIDTH(AW), .RETURN_BYTES(RB), .RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .address       (address),
    .req_valid     (req_valid),
    .data_valid    (data_valid),
    .cache_miss    (cache_miss),
    .resp_valid    (resp_valid),
    .resp_pc       (resp_pc),
    .perf_hits     (perf_hits),
    .perf_misses   (perf_misses),
    .dbg_state_o   (dbg_state_o)
  );

  // ---------------- scoreboard state ----------------
  logic [AW-1:0] exp_req_q[$];
  logic [AW-1:0] exp_resp_q[$];
  int            n_cmp = 0;
  int            n_fail = 0;
  bit            checking = 1'b0;

  // Reference model: next line to fetch, plus the (at most one) outstanding line.
  logic [AW-1:0] m_next_line;
  logic [AW-1:0] m_outstanding[$];
  logic [31:0]   m_hits;
  logic [31:0]   m_misses;

  // Cache model: answers one cycle after a request; a miss holds cache_miss for a burst.
  int            burst_left;
  bit            cache_pending;

  function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
    return a - (a % AW'(RB));
  endfunction

  task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (checking && !rst) begin
      if (req_valid) begin
        if (exp_req_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL req_unexpected: got req to %h expected no request (t=%0t)", address, $time);
        end else begin
          chk("req_addr", address, exp_req_q.pop_front());
        end
      end
      if (resp_valid) begin
        if (exp_resp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL resp_unexpected: got resp for %h expected no response (t=%0t)", resp_pc, $time);
        end else begin
          chk("resp_pc", resp_pc, exp_resp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    data_valid = 1'b0; cache_miss = 1'b0;
    burst_left = 0; cache_pending = 1'b0;
    m_next_line = line_of(RST_PC);
    m_outstanding.delete();
    m_hits = '0; m_misses = '0;
    @(posedge clk); #1;
    chk("rst_address",   address, line_of(RST_PC));
    chk("rst_req_valid", AW'(req_valid), '0);
    chk("rst_resp_valid", AW'(resp_valid), '0);
    chk("rst_perf_hits", AW'(perf_hits), '0);
    chk("rst_perf_misses", AW'(perf_misses), '0);
    chk("rst_state",     AW'(dbg_state_o), '0);
    rst = 1'b0;
  endtask

  // One clock cycle. miss_len>0 makes the answer to last cycle's request a miss of that length.
  task automatic step(input bit st, input bit rv, input logic [AW-1:0] rp, input int miss_len);
    bit dv, cm, want_req, want_resp, accept_miss;
    logic [AW-1:0] out_line;
    dv = 1'b0; cm = 1'b0;
    if (burst_left > 0) begin
      cm = 1'b1; burst_left--;
    end else if (cache_pending) begin
      if (miss_len > 0) begin cm = 1'b1; burst_left = miss_len - 1; end
      else dv = 1'b1;
    end
    stall = st; redirect_valid = rv; redirect_pc = rp; data_valid = dv; cache_miss = cm;

    out_line    = (m_outstanding.size() != 0) ? m_outstanding[0] : '0;
    want_resp   = dv && (m_outstanding.size() != 0) && !rv;
    accept_miss = cm && (m_outstanding.size() != 0) && !rv;
    want_req    = !st && !rv && !cm;
    if (want_resp) begin
      exp_resp_q.push_back(out_line);
      if (m_hits != 32'hFFFF_FFFF) m_hits++;
    end
    if (want_req) exp_req_q.push_back(m_next_line);
    m_outstanding.delete();
    if (rv) begin
      m_next_line = line_of(rp);
    end else if (accept_miss) begin
      m_next_line = out_line;
      if (m_misses != 32'hFFFF_FFFF) m_misses++;
    end else if (want_req) begin
      m_outstanding.push_back(m_next_line);
      m_next_line = m_next_line + AW'(RB);
    end
    cache_pending = want_req;
    @(posedge clk); #1;
  endtask

  task automatic run_hits(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] rp;
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    data_valid = 1'b0; cache_miss = 1'b0;
    checking = 1'b1;
    do_reset();

    // Sequential hits from reset.
    run_hits(4);

    // Miss on the line in flight, held five cycles, then replay.
    do_reset();
    run_hits(2);
    step(1'b0, 1'b0, '0, 5);
    run_hits(8);

    // Redirect while a hit returns: response dropped, target aligned down.
    step(1'b0, 1'b1, 64'h1234_5677, 0);
    run_hits(3);

    // Redirect during MISS_WAIT.
    step(1'b0, 1'b0, '0, 4);
    step(1'b0, 1'b1, 64'h4000_0008, 0);
    run_hits(6);

    // Stall for three cycles with a line in flight.
    step(1'b1, 1'b0, '0, 0);
    step(1'b1, 1'b0, '0, 0);
    step(1'b1, 1'b0, '0, 0);
    run_hits(3);

    // Address wrap at the top of the space.
    step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF5, 0);
    run_hits(4);

    // Reset in the middle of a miss.
    step(1'b0, 1'b0, '0, 6);
    step(1'b0, 1'b0, '0, 0);
    do_reset();
    run_hits(3);

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      rp = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FF00 | AW'($urandom_range(0, 255)))
                                        : {$urandom, $urandom};
      step($urandom_range(0, 6) == 0, $urandom_range(0, 14) == 0, rp,
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0);
    end
    run_hits(2);

`ifdef FETCH_PERF_CNT_EN
    // Preload counters near the top so the next hits and miss must saturate.
    force dut.perf_hits_q = 32'hFFFF_FFFE;
    force dut.perf_misses_q = 32'hFFFF_FFFF;
    #1;
    release dut.perf_hits_q;
    release dut.perf_misses_q;
    m_hits = 32'hFFFF_FFFE;
    m_misses = 32'hFFFF_FFFF;
    run_hits(4);
    step(1'b0, 1'b0, '0, 2);
    run_hits(4);
`endif

    // ---------------- final report ----------------
    chk("req_left",   AW'(exp_req_q.size()), '0);
    chk("resp_left",  AW'(exp_resp_q.size()), '0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_hits",   AW'(perf_hits), AW'(m_hits));
    chk("perf_misses", AW'(perf_misses), AW'(m_misses));
`else
    chk("perf_hits",   AW'(perf_hits), '0);
    chk("perf_misses", AW'(perf_misses), '0);
`endif
    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
